// File: rtl/serial_paralelo_pkg.sv
// Shared phy definitions: the idle/alignment comma and the receive alignment FSM encoding.
package serial_paralelo_pkg;

  localparam logic [7:0] COMMA_BC = 8'hBC;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_paralelo_if.sv
// Serial lane receive bundle: serial bit in, recovered byte, valid flag and link-active out.
interface serial_paralelo_if;

  logic       data_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic       active;

  modport master (output data_in, input data_out, input valid_out, input active);
  modport slave  (input data_in, output data_out, output valid_out, output active);

endinterface

// File: rtl/serial_paralelo.sv
// Serial-to-parallel receiver: MSB-first deserializer that locks byte phase on repeated
// commas and then presents each non-comma byte for one full byte period.
module serial_paralelo
  import serial_paralelo_pkg::*;
#(
  parameter int BC_COUNT = 4
) (
  input  logic              clk_32f,
  input  logic              reset,
  serial_paralelo_if.slave  lnk
);

  localparam logic [3:0] BC_TARGET = 4'(BC_COUNT);

  state_e      state_q, state_d;
  logic [7:0]  sr_q, sr_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  bc_cnt_q, bc_cnt_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        valid_q, valid_d;
  logic        active_q, active_d;

  logic [7:0]  byte_next;
  logic        boundary;
  logic        is_comma;

  assign byte_next = {sr_q[6:0], lnk.data_in};
  assign boundary  = (bit_cnt_q == 3'd7);
  assign is_comma  = (byte_next == COMMA_BC);

  always_comb begin
    state_d    = state_q;
    sr_d       = byte_next;
    bit_cnt_d  = bit_cnt_q;
    bc_cnt_d   = bc_cnt_q;
    data_out_d = data_out_q;
    valid_d    = valid_q;
    active_d   = active_q;

    unique case (state_q)
      SEARCH: begin
        // Any bit offset may match; a hit fixes the byte phase for good.
        if (is_comma) begin
          bit_cnt_d = 3'd0;
          bc_cnt_d  = 4'd1;
          if (BC_COUNT == 1) begin
            state_d  = ACTIVE;
            active_d = 1'b1;
          end else begin
            state_d = ALIGN;
          end
        end
      end
      ALIGN: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (is_comma) begin
            bc_cnt_d = bc_cnt_q + 4'd1;
            if ((bc_cnt_q + 4'd1) == BC_TARGET) begin
              state_d  = ACTIVE;
              active_d = 1'b1;
            end
          end else begin
            bc_cnt_d = 4'd0;
            state_d  = SEARCH;
          end
        end
      end
      ACTIVE: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (is_comma) begin
            valid_d = 1'b0;
          end else begin
            data_out_d = byte_next;
            valid_d    = 1'b1;
          end
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q    <= SEARCH;
      sr_q       <= 8'h00;
      bit_cnt_q  <= 3'd0;
      bc_cnt_q   <= 4'd0;
      data_out_q <= 8'h00;
      valid_q    <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      bc_cnt_q   <= bc_cnt_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      active_q   <= active_d;
    end
  end

  assign lnk.data_out  = data_out_q;
  assign lnk.valid_out = valid_q;
  assign lnk.active    = active_q;

endmodule

// File: tb/tb_serial_paralelo.sv
// Directed bench for the serial-to-parallel receiver with hand-computed expectations.
module tb_serial_paralelo;

  logic clk_32f;
  logic reset;
  int   n_cmp;
  int   n_err;

  serial_paralelo_if sif ();

  serial_paralelo #(.BC_COUNT(4)) dut (
    .clk_32f (clk_32f),
    .reset   (reset),
    .lnk     (sif.slave)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one bit, let the rising edge sample it, then settle 1 time unit past the edge.
  task automatic tick(input logic b);
    sif.data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) tick(b[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(b, 8);
  endtask

  task automatic chk_all(input string tag, input logic [7:0] d, input logic v, input logic a);
    chk({tag, "_data"},   32'(sif.data_out),  32'(d));
    chk({tag, "_valid"},  32'(sif.valid_out), 32'(v));
    chk({tag, "_active"}, 32'(sif.active),    32'(a));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick(1'($urandom_range(0, 1)));
      chk_all("reset", 8'h00, 1'b0, 1'b0);
    end
    reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    sif.data_in = 1'b0;

    // Reset held for 3 cycles with random serial data.
    do_reset(3);

    // Aligned lock: active must rise exactly on the LSB of the 4th comma.
    repeat (3) send_byte(8'hBC);
    chk("lock0_after3", 32'(sif.active), 32'd0);
    send_bits(8'hBC, 7);
    chk("lock0_bit7", 32'(sif.active), 32'd0);
    tick(1'b0);
    chk_all("lock0_4th", 8'h00, 1'b0, 1'b1);
    send_byte(8'hBC);
    chk_all("lock0_5th", 8'h00, 1'b0, 1'b1);

    // Data stream: A5, 3C, BC, 7E.
    send_byte(8'hA5);
    chk_all("ds_a5", 8'hA5, 1'b1, 1'b1);
    send_byte(8'h3C);
    chk_all("ds_3c", 8'h3C, 1'b1, 1'b1);
    send_byte(8'hBC);
    chk_all("ds_bc", 8'h3C, 1'b0, 1'b1);
    send_byte(8'h7E);
    chk_all("ds_7e", 8'h7E, 1'b1, 1'b1);
    send_bits(8'hBC, 7);
    chk_all("ds_hold7", 8'h7E, 1'b1, 1'b1);
    tick(1'b0);
    chk_all("ds_commadrop", 8'h7E, 1'b0, 1'b1);

    // Mid-stream reset during a data byte, then a full re-lock.
    send_bits(8'h55, 3);
    reset = 1'b1;
    tick(1'b1);
    chk_all("midrst", 8'h00, 1'b0, 1'b0);
    reset = 1'b0;
    repeat (3) send_byte(8'hBC);
    chk_all("relock_3", 8'h00, 1'b0, 1'b0);
    send_byte(8'hBC);
    chk_all("relock_4", 8'h00, 1'b0, 1'b1);

    // Misaligned lock: 3 leading bits shift the byte phase.
    do_reset(1);
    tick(1'b1);
    tick(1'b0);
    tick(1'b1);
    repeat (3) send_byte(8'hBC);
    chk("mis_after3", 32'(sif.active), 32'd0);
    send_byte(8'hBC);
    chk_all("mis_lock", 8'h00, 1'b0, 1'b1);
    send_byte(8'hA5);
    chk_all("mis_a5", 8'hA5, 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tick(1'((8'hBC >> (7 - i)) & 8'h01));
      chk_all("mis_hold", 8'hA5, 1'b1, 1'b1);
    end
    tick(1'b0);
    chk_all("mis_drop", 8'hA5, 1'b0, 1'b1);

    // Broken alignment: BC, BC, 3C falls back to search; 4 fresh commas lock.
    do_reset(1);
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h3C);
    chk("brk_after3c", 32'(sif.active), 32'd0);
    repeat (3) send_byte(8'hBC);
    chk("brk_after3bc", 32'(sif.active), 32'd0);
    send_byte(8'hBC);
    chk_all("brk_lock", 8'h00, 1'b0, 1'b1);
    send_byte(8'h7E);
    chk_all("brk_data", 8'h7E, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
